// File: rtl/dmem.sv
`default_nettype none
// ============================================================================
// Module   : dmem
// Brief    : MEM-stage data memory for the swt16 core. One write port, one
//            registered read port with write-first forwarding. After every
//            reset the array is swept to zero before accesses are accepted.
// Revision : 1.0 - initial release
// ============================================================================
module dmem #(
   parameter int DMEM_ADDR_WIDTH = 12,
   parameter int DMEM_WORD_WIDTH = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_rd_addr,
   input  logic [DMEM_ADDR_WIDTH-1:0] in_mem_wr_addr,
   input  logic [DMEM_WORD_WIDTH-1:0] in_mem_wr_word,
   input  logic                       in_mem_write_en,
   output logic [DMEM_WORD_WIDTH-1:0] out_mem_rd_word,
   output logic                       out_ready,
   output logic                       out_wr_dropped
);

   localparam int                         c_DEPTH     = 1 << DMEM_ADDR_WIDTH;
   localparam logic [0:0]                 c_S_CLEAR   = 1'b0;
   localparam logic [0:0]                 c_S_RUN     = 1'b1;
   localparam logic [DMEM_ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

   logic [DMEM_WORD_WIDTH-1:0] r_mem [c_DEPTH];

   logic [0:0]                 r_state;
   logic [0:0]                 w_state_nxt;
   logic [DMEM_ADDR_WIDTH-1:0] r_clear_ptr;
   logic                       w_sweep_last;
   logic                       w_mem_we;
   logic [DMEM_ADDR_WIDTH-1:0] w_mem_waddr;
   logic [DMEM_WORD_WIDTH-1:0] w_mem_wdata;
   logic                       w_collide;
   logic [DMEM_WORD_WIDTH-1:0] r_rd_word;
   logic                       r_ready;
   logic                       r_wr_dropped;

   assign w_sweep_last = (r_clear_ptr == c_LAST_ADDR);
   // Same-cycle read and write of one address returns the new word.
   assign w_collide    = in_mem_write_en && (in_mem_wr_addr == in_mem_rd_addr);

   // State register: reset always restarts the clear sweep.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= c_S_CLEAR;
      else       r_state <= w_state_nxt;
   end

   // Next state: leave CLEAR on the edge that zeroes the last address; RUN is terminal.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_CLEAR: if (w_sweep_last) w_state_nxt = c_S_RUN;
         default:   w_state_nxt = c_S_RUN;
      endcase
   end

   // Write-port steering: sweep owns the port in CLEAR, the core owns it in RUN.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_waddr = '0;
      w_mem_wdata = '0;
      case (r_state)
         c_S_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clear_ptr;
            w_mem_wdata = '0;
         end
         default: begin
            w_mem_we    = in_mem_write_en;
            w_mem_waddr = in_mem_wr_addr;
            w_mem_wdata = in_mem_wr_word;
         end
      endcase
   end

   // Sweep pointer: advances every CLEAR edge and wraps to 0 after the last address.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                    r_clear_ptr <= '0;
      else if (r_state == c_S_CLEAR) r_clear_ptr <= r_clear_ptr + 1'b1;
   end

   // Storage array: deliberately not reset, the sweep is what clears it.
   always_ff @(posedge clock) begin
      if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
   end

   // Registered read port: zero during the sweep, write-first on collision.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                     r_rd_word <= '0;
      else if (r_state == c_S_CLEAR) r_rd_word <= '0;
      else if (w_collide)            r_rd_word <= in_mem_wr_word;
      else                           r_rd_word <= r_mem[in_mem_rd_addr];
   end

   // Ready flag: registered copy of "next state is RUN".
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_ready <= 1'b0;
      else       r_ready <= (w_state_nxt == c_S_RUN);
   end

   // Sticky flag for write requests that arrived while the sweep held the port.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                        r_wr_dropped <= 1'b0;
      else if ((r_state == c_S_CLEAR) && in_mem_write_en) r_wr_dropped <= 1'b1;
   end

   assign out_mem_rd_word = r_rd_word;
   assign out_ready       = r_ready;
   assign out_wr_dropped  = r_wr_dropped;

endmodule
`default_nettype wire
